// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder
//   Watches the multiplexed AN/CA scan lines of a seven-segment display and
//   rebuilds the 32-bit hex value on show. Each digit is captured once after
//   its AN/CA pattern has held steady for SETTLE_CYCLES samples. A frame is
//   published when all eight digits have been captured.
//
// Parameters
//   SETTLE_CYCLES   identical consecutive samples needed before capture (>=2)
//   TIMEOUT_CYCLES  cycles with no digit capture before stale asserts
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   an[7:0]      digit enables, active-low (an[i]=0 selects digit i)
//   ca[7:0]      segments, active-low, ca[0]=a .. ca[6]=g, ca[7]=dp
//   value[31:0]  last complete frame, digit i -> value[4i+3:4i]
//   frame_valid  one-cycle pulse when value updates
//   digit_err    per-digit flag: glyph was not a legal hex glyph
//   multi_an     sticky: more than one anode low at a settled sample
//   stale        no digit captured for TIMEOUT_CYCLES
//
// Build option
//   SSD_SYNC_EN  adds a 2-flop synchronizer on an/ca ahead of the sample
//                register (for off-chip pins); adds 2 cycles of latency.

module seven_segment_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [7:0]  ca,
    output logic [31:0] value,
    output logic        frame_valid,
    output logic [7:0]  digit_err,
    output logic        multi_an,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_PRE = SW'(SETTLE_CYCLES - 2);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES);

    // Glyph lookup: returns {bad, nibble}; dp is not part of the glyph.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: return 5'h00;
            7'b1111001: return 5'h01;
            7'b0100100: return 5'h02;
            7'b0110000: return 5'h03;
            7'b0011001: return 5'h04;
            7'b0010010: return 5'h05;
            7'b0000010: return 5'h06;
            7'b1111000: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0010000: return 5'h09;
            7'b0001000: return 5'h0A;
            7'b0000011: return 5'h0B;
            7'b1000110: return 5'h0C;
            7'b0100001: return 5'h0D;
            7'b0000110: return 5'h0E;
            7'b0001110: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    logic [15:0] raw;

`ifdef SSD_SYNC_EN
    // Idle (all high) reset value so the synchronizer never presents a
    // spurious multi-anode pattern coming out of reset.
    logic [15:0] sync0, sync1;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 16'hFFFF;
            sync1 <= 16'hFFFF;
        end else begin
            sync0 <= {an, ca};
            sync1 <= sync0;
        end
    end
    assign raw = sync1;
`else
    assign raw = {an, ca};
`endif

    logic [15:0]      smp, prev;
    logic [SW-1:0]    stab;
    logic             captured;
    logic             cap_d;
    logic [TW-1:0]    tcnt;
    logic [7:0]       seen;
    logic [7:0][3:0]  shadow;
    logic [7:0]       err_sh;

    logic [7:0] s_an;
    logic       stable, cap, is_blank, is_one, cap_digit;
    logic [4:0] dec;

    assign s_an     = smp[15:8];
    assign stable   = (smp == prev);
    // Capture lands on the same edge that stab reaches SETTLE_CYCLES-1.
    assign cap      = stable && (stab == STAB_PRE) && !captured;
    assign is_blank = (s_an == 8'hFF);
    assign is_one   = $onehot(~s_an);
    assign cap_digit = cap && is_one;
    assign dec      = decode(smp[6:0]);
    assign stale    = (tcnt == TMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            smp         <= 16'hFFFF;
            prev        <= 16'hFFFF;
            stab        <= '0;
            captured    <= 1'b0;
            cap_d       <= 1'b0;
            tcnt        <= '0;
            seen        <= '0;
            shadow      <= '0;
            err_sh      <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            digit_err   <= '0;
            multi_an    <= 1'b0;
        end else begin
            prev <= smp;
            smp  <= raw;

            if (!stable) begin
                stab     <= '0;
                captured <= 1'b0;
            end else begin
                if (stab != STAB_MAX)
                    stab <= stab + SW'(1);
                if (cap)
                    captured <= 1'b1;
            end

            if (cap && !is_blank && !is_one)
                multi_an <= 1'b1;

            if (cap_digit)
                tcnt <= '0;
            else if (tcnt != TMAX)
                tcnt <= tcnt + TW'(1);

            for (int i = 0; i < 8; i++) begin
                if (cap_digit && !s_an[i]) begin
                    shadow[i] <= dec[3:0];
                    err_sh[i] <= dec[4];
                end
            end

            // Frame completion looks one cycle after a capture so that the
            // shadow registers already hold the final digit.
            cap_d       <= cap_digit;
            frame_valid <= 1'b0;
            if (cap_d && seen == 8'hFF) begin
                value       <= shadow;
                digit_err   <= err_sh;
                frame_valid <= 1'b1;
                seen        <= cap_digit ? ~s_an : 8'h00;
            end else if (cap_digit) begin
                seen <= seen | ~s_an;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
module tb_seven_segment_scan_decoder;

    localparam int S = 4;
    localparam int T = 64;
`ifdef SSD_SYNC_EN
    localparam int SY = 2;
`else
    localparam int SY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  an  = 8'hFF;
    logic [7:0]  ca  = 8'hFF;
    logic [31:0] value;
    logic        frame_valid;
    logic [7:0]  digit_err;
    logic        multi_an;
    logic        stale;

    seven_segment_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .an(an), .ca(ca),
        .value(value), .frame_valid(frame_valid), .digit_err(digit_err),
        .multi_an(multi_an), .stale(stale)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int frames_pushed = 0;

    typedef struct packed { logic [31:0] v; logic [7:0] e; } frame_t;
    frame_t exp_q[$];

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: what the display has shown so far in this frame.
    logic [3:0] m_nib [8];
    logic [7:0] m_err;
    logic [7:0] m_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] seg);
        for (int n = 0; n < 16; n++)
            if (glyph[n] == seg) return {1'b0, 4'(n)};
        return 5'h10;
    endfunction

    function automatic logic [6:0] bad_glyph();
        logic [6:0] g;
        logic [4:0] d;
        do begin
            g = 7'($urandom);
            d = ref_decode(g);
        end while (!d[4]);
        return g;
    endfunction

    // A pattern held for at least S samples on exactly one anode is a digit
    // capture; shorter holds are glitches and leave the model untouched.
    task automatic model_step(input logic [7:0] a, input logic [7:0] c, input int n);
        logic [4:0]  d;
        logic [31:0] v;
        int idx;
        if (n < S || a == 8'hFF || $countones(~a) != 1) return;
        idx = 0;
        for (int k = 0; k < 8; k++) if (!a[k]) idx = k;
        d = ref_decode(c[6:0]);
        m_nib[idx]  = d[4] ? 4'h0 : d[3:0];
        m_err[idx]  = d[4];
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin
            for (int k = 0; k < 8; k++) v[4*k +: 4] = m_nib[k];
            exp_q.push_back('{v: v, e: m_err});
            frames_pushed++;
            m_seen = 8'h00;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
        m_err  = 8'h00;
        m_seen = 8'h00;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] c, input int n);
        an = a;
        ca = c;
        model_step(a, c, n);
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        drive(8'hFF, 8'($urandom), n);
    endtask

    task automatic show_ca(input int i, input logic [6:0] g, input int hold);
        logic [7:0] sel;
        sel = 8'd1 << i;
        drive(~sel, {1'($urandom), g}, hold);
        blank(1 + $urandom % 3);
    endtask

    task automatic show(input int i, input int nib, input int hold);
        show_ca(i, glyph[nib], hold);
    endtask

    task automatic do_reset();
        blank(8 + SY);
        check("queue_drained_before_reset", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Scoreboard monitor: every frame_valid pulse consumes one expected frame.
    always @(negedge clk) begin
        frame_t f;
        if (!rst && frame_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got value %0h err %0h expected no frame",
                         value, digit_err);
            end else begin
                f = exp_q.pop_front();
                check("frame_value", 64'(value), 64'(f.v));
                check("frame_err", 64'(digit_err), 64'(f.e));
            end
        end
    end

    initial begin
        logic [31:0] lv;
        logic [31:0] vs;
        logic [7:0]  sel;
        int lat, target, guard, i, r;

        model_clear();
        repeat (3) @(negedge clk);
        check("rst_value", 64'(value), 64'd0);
        check("rst_frame_valid", 64'(frame_valid), 64'd0);
        check("rst_digit_err", 64'(digit_err), 64'd0);
        check("rst_multi_an", 64'(multi_an), 64'd0);
        check("rst_stale", 64'(stale), 64'd0);

        // Stale: blank display for T cycles, then one digit clears it.
        rst = 1'b0;
        an  = 8'hFF;
        repeat (T - 1) @(negedge clk);
        check("stale_before_timeout", 64'(stale), 64'd0);
        @(negedge clk);
        check("stale_at_timeout", 64'(stale), 64'd1);
        an = 8'hFE;
        ca = {1'b0, glyph[5]};
        model_step(8'hFE, ca, S + SY + 1);
        repeat (S + SY) @(negedge clk);
        check("stale_held_until_capture", 64'(stale), 64'd1);
        @(negedge clk);
        check("stale_dropped_after_capture", 64'(stale), 64'd0);
        blank(2);

        // Loopback of a known value.
        lv = 32'h0F1E_2D3C;
        for (int k = 0; k < 8; k++) show(k, int'(lv[4*k +: 4]), S + $urandom % 3);
        blank(8 + SY);
        check("loopback_value", 64'(value), 64'h0F1E2D3C);
        check("loopback_err", 64'(digit_err), 64'd0);

        // Glitch: digit 0 toggling every 2 cycles is never captured.
        for (int k = 1; k < 8; k++) show(k, int'($urandom % 16), S);
        for (int k = 0; k < 8; k++) drive(8'hFE, {1'b0, glyph[(k % 2) ? 8 : 0]}, 2);
        drive(8'hFE, {1'b0, glyph[10]}, 12);
        blank(3);
        for (int k = 1; k < 8; k++) show(k, int'($urandom % 16), S);
        show(0, int'($urandom % 16), S);

        // Bad glyph on digit 5.
        for (int k = 0; k < 8; k++) begin
            if (k == 5) show_ca(5, 7'h7F, S);
            else        show(k, int'($urandom % 16), S + 1);
        end
        blank(8 + SY);
        vs = value;
        check("bad_glyph_err", 64'(digit_err), 64'h20);
        check("bad_glyph_nibble", 64'(vs[23:20]), 64'd0);

        // Multiple anodes low: sticky flag, seen untouched.
        check("multi_an_clear", 64'(multi_an), 64'd0);
        drive(8'hFC, {1'b0, glyph[3]}, S + 2);
        blank(6 + SY);
        check("multi_an_set", 64'(multi_an), 64'd1);
        for (int k = 0; k < 8; k++) show(k, int'($urandom % 16), S);
        blank(4);
        check("multi_an_sticky", 64'(multi_an), 64'd1);

        // Reset mid-frame discards the partial frame.
        do_reset();
        for (int k = 0; k < 5; k++) show(k, int'($urandom % 16), S);
        do_reset();
        check("midframe_rst_value", 64'(value), 64'd0);
        check("midframe_rst_multi_an", 64'(multi_an), 64'd0);
        check("midframe_rst_err", 64'(digit_err), 64'd0);
        for (int k = 5; k < 8; k++) show(k, int'($urandom % 16), S);
        for (int k = 0; k < 5; k++) show(k, int'($urandom % 16), S);

        // Latency from final digit becoming stable to frame_valid.
        do_reset();
        for (int k = 0; k < 7; k++) show(k, int'($urandom % 16), S);
        an = 8'h7F;
        ca = {1'b0, glyph[int'($urandom % 16)]};
        model_step(an, ca, S + 8);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_valid) begin
                lat = k - 1;
                break;
            end
        end
        check("frame_latency", 64'(lat), 64'(S + 1 + SY));
        blank(3);

        // Randomized frames with glitches and bad glyphs mixed in.
        for (int f = 0; f < 25; f++) begin
            target = frames_pushed + 1;
            guard  = 0;
            while (frames_pushed < target && guard < 400) begin
                guard++;
                i = int'($urandom % 8);
                r = int'($urandom % 10);
                if (r < 6) begin
                    show(i, int'($urandom % 16), S + int'($urandom % 4));
                end else if (r < 7) begin
                    show_ca(i, bad_glyph(), S);
                end else begin
                    sel = 8'd1 << i;
                    drive(~sel, 8'($urandom), 1 + int'($urandom % (S - 1)));
                    blank(1 + $urandom % 3);
                end
            end
        end

        blank(20);
        check("all_frames_seen", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
